// File: rtl/create_ndigit_code.sv
//------------------------------------------------------------------------------
// create_ndigit_code
//   Produces an N-digit code from a free-running Galois LFSR and holds it
//   until the next request. Optional macro: CODE_REPEAT_REJECT_EN
//   (rejects a candidate equal to the current code).
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module create_ndigit_code #(
    parameter int                NUM_DIGITS = 4,
    parameter int                DIGIT_BITS = 2,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                COUNT_W    = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             gen_req,
    output logic [NUM_DIGITS*DIGIT_BITS-1:0] code,
    output logic                             code_valid,
    output logic [COUNT_W-1:0]               gen_count
);

    localparam int CODE_W = NUM_DIGITS * DIGIT_BITS;

    typedef enum logic [0:0] {
        S_GEN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [LFSR_W-1:0]   w_lfsr_next;
    logic [CODE_W-1:0]   w_cand;
    logic                w_accept;
    logic                w_cnt_max;

    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
    assign w_cand      = r_lfsr[CODE_W-1:0];
    assign w_cnt_max   = (gen_count == {COUNT_W{1'b1}});

`ifdef CODE_REPEAT_REJECT_EN
    // The first code after reset has no predecessor, so it is always taken.
    logic r_first;

    assign w_accept = r_first || (w_cand != code);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_first <= 1'b1;
        end else if (r_state == S_GEN && w_accept) begin
            r_first <= 1'b0;
        end
    end
`else
    assign w_accept = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr     <= SEED;
            r_state    <= S_GEN;
            code       <= '0;
            code_valid <= 1'b0;
            gen_count  <= '0;
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_GEN: begin
                    if (w_accept) begin
                        code       <= w_cand;
                        code_valid <= 1'b1;
                        r_state    <= S_HOLD;
                        if (!w_cnt_max) begin
                            gen_count <= gen_count + 1'b1;
                        end
                    end else begin
                        code_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (gen_req) begin
                        code_valid <= 1'b0;
                        r_state    <= S_GEN;
                    end
                end
                default: begin
                    r_state    <= S_GEN;
                    code_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_create_ndigit_code.sv
//------------------------------------------------------------------------------
// tb_create_ndigit_code
//   Directed and random checks of two configurations against a behavioural model.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_create_ndigit_code;

    logic       clk;
    logic       reset;
    logic       gen_req;
    logic [7:0] code0;
    logic       valid0;
    logic [7:0] cnt0;
    logic [0:0] code1;
    logic       valid1;
    logic [1:0] cnt1;

    int n_cmp  = 0;
    int n_fail = 0;

    create_ndigit_code u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .gen_req    (gen_req),
        .code       (code0),
        .code_valid (valid0),
        .gen_count  (cnt0)
    );

    create_ndigit_code #(
        .NUM_DIGITS (1),
        .DIGIT_BITS (1),
        .COUNT_W    (2)
    ) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .gen_req    (gen_req),
        .code       (code1),
        .code_valid (valid1),
        .gen_count  (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: index 0 = default build, index 1 = 1-bit code, 2-bit count
    logic [15:0] m_lfsr  [2];
    logic [7:0]  m_code  [2];
    logic        m_valid [2];
    int          m_cnt   [2];
    bit          m_gen   [2];
    bit          m_first [2];
    logic [7:0]  c_mask  [2] = '{8'hFF, 8'h01};
    int          c_max   [2] = '{255, 3};
`ifdef CODE_REPEAT_REJECT_EN
    bit          c_rej = 1'b1;
`else
    bit          c_rej = 1'b0;
`endif

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic model_step(input bit r, input bit g);
        logic [7:0] cand;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_lfsr[d]  = 16'hACE1;
                m_code[d]  = 8'h00;
                m_valid[d] = 1'b0;
                m_cnt[d]   = 0;
                m_gen[d]   = 1'b1;
                m_first[d] = 1'b1;
            end else begin
                cand = m_lfsr[d][7:0] & c_mask[d];
                if (m_gen[d]) begin
                    if (m_first[d] || !c_rej || cand != m_code[d]) begin
                        m_code[d]  = cand;
                        m_valid[d] = 1'b1;
                        m_cnt[d]   = (m_cnt[d] < c_max[d]) ? m_cnt[d] + 1 : m_cnt[d];
                        m_gen[d]   = 1'b0;
                        m_first[d] = 1'b0;
                    end else begin
                        m_valid[d] = 1'b0;
                    end
                end else if (g) begin
                    m_gen[d]   = 1'b1;
                    m_valid[d] = 1'b0;
                end
                m_lfsr[d] = lfsr_next(m_lfsr[d]);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] prev_code;
    logic       prev_valid;

    task automatic cycle(input bit r, input bit g);
        prev_code  = code0;
        prev_valid = valid0;
        reset      = r;
        gen_req    = g;
        @(posedge clk);
        model_step(r, g);
        #1;
        chk("code0",  {24'h0, code0},      {24'h0, m_code[0]});
        chk("valid0", {31'h0, valid0},     {31'h0, m_valid[0]});
        chk("cnt0",   {24'h0, cnt0},       m_cnt[0]);
        chk("code1",  {31'h0, code1},      {24'h0, m_code[1]});
        chk("valid1", {31'h0, valid1},     {31'h0, m_valid[1]});
        chk("cnt1",   {30'h0, cnt1},       m_cnt[1]);
        if (!r && prev_valid && valid0) begin
            chk("stable0", {24'h0, code0}, {24'h0, prev_code});
        end
    endtask

    initial begin
        reset   = 1'b1;
        gen_req = 1'b0;

        // Reset for 3 cycles, then first code right after release
        repeat (3) cycle(1'b1, 1'b0);
        chk("rst_code",  {24'h0, code0},  32'h0);
        chk("rst_valid", {31'h0, valid0}, 32'h0);
        cycle(1'b0, 1'b0);
        chk("first_code",  {24'h0, code0},  32'hE1);
        chk("first_valid", {31'h0, valid0}, 32'h1);
        chk("first_cnt",   {24'h0, cnt0},   32'h1);

        // Single request pulse on first HOLD cycle
        cycle(1'b0, 1'b1);
        chk("req_valid_low", {31'h0, valid0}, 32'h0);
        cycle(1'b0, 1'b0);
        chk("second_code", {24'h0, code0}, 32'h38);
        chk("second_cnt",  {24'h0, cnt0},  32'h2);
        chk("sat_cnt1",    {30'h0, cnt1},  32'h2);

        // Continuous requests from a fresh reset
        repeat (2) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0);
        chk("burst_cnt",  {24'h0, cnt0}, 32'h6);
        chk("sat_cnt1b",  {30'h0, cnt1}, 32'h3);

        // Reset while generating, then reset while holding
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        chk("rst_gen_valid", {31'h0, valid0}, 32'h0);
        chk("rst_gen_cnt",   {24'h0, cnt0},   32'h0);
        cycle(1'b0, 1'b1);
        chk("rel_code", {24'h0, code0}, 32'hE1);
        cycle(1'b1, 1'b0);
        chk("rst_hold_code", {24'h0, code0}, 32'h0);
        cycle(1'b0, 1'b0);
        chk("rel2_code", {24'h0, code0}, 32'hE1);
        chk("rel2_cnt",  {24'h0, cnt0},  32'h1);

        // Random requests with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/create_ndigit_code.md
CREATE_NDIGIT_CODE -- requirements
Module: create_ndigit_code

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of code digits.
REQ-002 SHALL have parameter DIGIT_BITS, default 2, bits per digit; derived CODE_W = NUM_DIGITS*DIGIT_BITS.
REQ-003 SHALL have parameter LFSR_W, default 16, LFSR width; CODE_W <= LFSR_W SHALL hold.
REQ-004 SHALL have parameter TAPS, default 16'hB400, Galois feedback mask.
REQ-005 SHALL have parameter SEED, default 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-006 SHALL have parameter COUNT_W, default 8, width of gen_count.
REQ-007 clk  input  1  single clock; all state updates on posedge clk.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 gen_req  input  1  request a new code; sampled only in HOLD.
REQ-010 code  output  CODE_W  current code; digit k = code[k*DIGIT_BITS +: DIGIT_BITS].
REQ-011 code_valid  output  1  high while code is held and stable.
REQ-012 gen_count  output  COUNT_W  number of codes accepted since reset, saturating.

Function
REQ-013 LFSR SHALL advance every non-reset cycle, all states: lsb=1 -> (lfsr>>1)^TAPS; lsb=0 -> lfsr>>1.
REQ-014 FSM SHALL have two states: GEN (sampling) and HOLD (code stable).
REQ-015 In GEN, candidate = lfsr[CODE_W-1:0] (pre-advance value) at each edge; if accepted: code<=candidate, code_valid<=1, gen_count increments, state<=HOLD.
REQ-016 In GEN, a rejected candidate SHALL leave code unchanged, code_valid=0, state GEN; retry next cycle.
REQ-017 In HOLD with gen_req=1: state<=GEN, code_valid<=0, code unchanged; with gen_req=0: all held.
REQ-018 Latency: gen_req seen at edge n -> code_valid low after n, new code valid after edge n+1 (no rejection).
REQ-019 gen_req in GEN SHALL be ignored (not queued).
REQ-020 gen_req held high SHALL yield a new code every 2 cycles (no rejection).
REQ-021 gen_count SHALL saturate at 2^COUNT_W-1, no wrap.
REQ-022 code SHALL never change while code_valid=1.

Reset
REQ-023 reset at an edge: lfsr<=SEED, state<=GEN, code<=0, code_valid<=0, gen_count<=0.
REQ-024 First post-reset code SHALL always be accepted (no previous code); it equals SEED[CODE_W-1:0] one edge after reset release.
REQ-025 reset in any state, including mid-GEN retry, SHALL override gen_req and all updates.

Configuration
REQ-026 Macro CODE_REPEAT_REJECT_EN: defined -> candidate equal to current code SHALL be rejected (except first after reset); undefined -> every candidate accepted, GEN always lasts one cycle.

Verification
REQ-027 Defaults, reset 3 cycles then release -> after 1 edge code=8'hE1, code_valid=1, gen_count=1.
REQ-028 Defaults, gen_req pulse on first HOLD cycle -> code_valid=0 for 1 cycle, then code=8'h38 (lfsr 16'h7138), gen_count=2.
REQ-029 Defaults, gen_req high 10 cycles in HOLD, then low -> code_valid toggles every cycle, gen_count=6, code stable afterwards.
REQ-030 NUM_DIGITS=1, DIGIT_BITS=1, macro defined, 200 gen_req pulses -> each accepted code differs from previous (alternating 0/1); macro undefined -> GEN always 1 cycle.
REQ-031 COUNT_W=2, 5 requests -> gen_count saturates at 3.
REQ-032 reset asserted during GEN retry and during HOLD -> all outputs at reset values next edge; sequence after release identical to REQ-027.
